// File: rtl/param_password_lock.sv
// param_password_lock
//
// Serial password lock. Digits arrive one per digitValid strobe and are
// compared against a stored password. Consecutive failed attempts are counted,
// and reaching MAX_FAILS enters lockdown. Lockdown is released only by the
// master sequence. While unlocked, setMode lets the user enter a new password.
//
// Parameters:
//   DIGIT_W    bits per digit
//   PW_LEN     digits per password / master code (>= 2)
//   MAX_FAILS  consecutive failures that trigger lockdown (>= 1)
//   DEFAULT_PW password loaded at reset, digit k at [k*DIGIT_W +: DIGIT_W]
//   MASTER_PW  lockdown release code, packed the same way
//
// Ports:
//   CLK           clock, rising edge
//   RST           synchronous active-low reset
//   setMode       level request to program a new password (UNLOCKED/SET only)
//   digitValid    one digit presented this cycle
//   digit         digit value
//   unlockLight   last attempt matched
//   errorLight    last attempt failed, no lockdown
//   warningLight  lockdown active
//   dbgState      FSM state (ENTRY=0 UNLOCKED=1 ERROR=2 SET=3 LOCKED=4)
//   dbgIndex      current digit position
//   dbgFailCount  consecutive failure count
module param_password_lock #(
  parameter int DIGIT_W   = 4,
  parameter int PW_LEN    = 4,
  parameter int MAX_FAILS = 3,
  parameter logic [PW_LEN*DIGIT_W-1:0] DEFAULT_PW = 16'h4321,
  parameter logic [PW_LEN*DIGIT_W-1:0] MASTER_PW  = 16'h9210
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           setMode,
  input  logic                           digitValid,
  input  logic [DIGIT_W-1:0]             digit,
  output logic                           unlockLight,
  output logic                           errorLight,
  output logic                           warningLight,
  output logic [2:0]                     dbgState,
  output logic [$clog2(PW_LEN)-1:0]      dbgIndex,
  output logic [$clog2(MAX_FAILS+1)-1:0] dbgFailCount
);

  localparam int IDX_W = $clog2(PW_LEN);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PW_LEN - 1);
  localparam logic [FC_W-1:0]  FAIL_LIM = FC_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    ENTRY    = 3'd0,
    UNLOCKED = 3'd1,
    ERROR    = 3'd2,
    SET      = 3'd3,
    LOCKED   = 3'd4
  } state_t;

  state_t             stateReg, stateNext;
  logic [IDX_W-1:0]   idxReg, idxNext;
  logic               missReg, missNext;
  logic [FC_W-1:0]    failReg, failNext;
  logic [DIGIT_W-1:0] pwReg [PW_LEN];
  logic [DIGIT_W-1:0] pwNext [PW_LEN];
  logic [DIGIT_W-1:0] stageReg [PW_LEN];
  logic [DIGIT_W-1:0] stageNext [PW_LEN];
  logic [DIGIT_W-1:0] masterArr [PW_LEN];
  logic               missAll;
  logic [FC_W-1:0]    failInc;

  always_comb begin
    for (int k = 0; k < PW_LEN; k++) begin
      masterArr[k] = MASTER_PW[k*DIGIT_W +: DIGIT_W];
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    idxNext   = idxReg;
    missNext  = missReg;
    failNext  = failReg;
    pwNext    = pwReg;
    stageNext = stageReg;
    missAll   = missReg | (digit != pwReg[idxReg]);
    failInc   = failReg + 1'b1;

    case (stateReg)
      ENTRY: begin
        if (digitValid) begin
          if (idxReg == LAST_IDX) begin
            idxNext  = '0;
            missNext = 1'b0;
            if (!missAll) begin
              stateNext = UNLOCKED;
              failNext  = '0;
            end else if (failInc == FAIL_LIM) begin
              stateNext = LOCKED;
              failNext  = FAIL_LIM;
            end else begin
              stateNext = ERROR;
              failNext  = failInc;
            end
          end else begin
            idxNext  = idxReg + 1'b1;
            missNext = missAll;
          end
        end
      end

      UNLOCKED, ERROR: begin
        // setMode is honoured only from UNLOCKED and beats a coincident digit.
        if (stateReg == UNLOCKED && setMode) begin
          stateNext = SET;
          idxNext   = '0;
        end else if (digitValid) begin
          // The digit starts a fresh attempt as its first digit.
          stateNext = ENTRY;
          idxNext   = IDX_W'(1);
          missNext  = (digit != pwReg[0]);
        end
      end

      SET: begin
        if (!setMode) begin
          stateNext = ENTRY;
          idxNext   = '0;
          missNext  = 1'b0;
        end else if (digitValid) begin
          stageNext[idxReg] = digit;
          if (idxReg == LAST_IDX) begin
            // Commit includes the digit arriving on this same edge.
            pwNext    = stageNext;
            stateNext = ENTRY;
            idxNext   = '0;
          end else begin
            idxNext = idxReg + 1'b1;
          end
        end
      end

      LOCKED: begin
        if (digitValid) begin
          if (digit != masterArr[idxReg]) begin
            idxNext = '0;
          end else if (idxReg == LAST_IDX) begin
            stateNext = ENTRY;
            idxNext   = '0;
            failNext  = '0;
          end else begin
            idxNext = idxReg + 1'b1;
          end
        end
      end

      default: begin
        stateNext = ENTRY;
        idxNext   = '0;
        missNext  = 1'b0;
      end
    endcase
  end

  // State and output registers; lights are decoded from the next state so
  // they change on the edge that samples the final digit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stateReg     <= ENTRY;
      idxReg       <= '0;
      missReg      <= 1'b0;
      failReg      <= '0;
      unlockLight  <= 1'b0;
      errorLight   <= 1'b0;
      warningLight <= 1'b0;
      for (int k = 0; k < PW_LEN; k++) begin
        pwReg[k]    <= DEFAULT_PW[k*DIGIT_W +: DIGIT_W];
        stageReg[k] <= '0;
      end
    end else begin
      stateReg     <= stateNext;
      idxReg       <= idxNext;
      missReg      <= missNext;
      failReg      <= failNext;
      pwReg        <= pwNext;
      stageReg     <= stageNext;
      unlockLight  <= (stateNext == UNLOCKED);
      errorLight   <= (stateNext == ERROR);
      warningLight <= (stateNext == LOCKED);
    end
  end

  assign dbgState     = stateReg;
  assign dbgIndex     = idxReg;
  assign dbgFailCount = failReg;

endmodule
